// File: rtl/alu_bist_ctrl.sv
// BIST sequencer for the 1-bit ALU slice: sweeps {A,B}, compares five outputs, counts mismatches.
// Optional failure capture port pair enabled by `define ALU_BIST_FAIL_LOG_EN.
module alu_bist_ctrl #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned ROUNDS  = 4,
   parameter int unsigned ERR_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_x,
   input  logic [4:0]       alu_result,
   output logic             busy,
   output logic             done,
   output logic             pass,
`ifdef ALU_BIST_FAIL_LOG_EN
   output logic             fail_valid,
   output logic [7:0]       fail_vec,
`endif
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

   state_t           r_state;
   logic [1:0]       r_idx;
   logic [3:0]       r_lat;
   logic [7:0]       r_round;
   logic [ERR_W-1:0] r_err;
   logic             r_a;
   logic             r_b;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
`ifdef ALU_BIST_FAIL_LOG_EN
   logic             r_fail_valid;
   logic [7:0]       r_fail_vec;
`endif

   logic [4:0]       w_golden;
   logic             w_mismatch;
   logic [ERR_W-1:0] w_err_next;
   logic [1:0]       w_idx_next;
   logic             w_last_vec;
   logic             w_last_round;
   logic             w_lat_end;

   always_comb begin
      w_golden     = {r_a | r_b, ~(r_a ^ r_b), r_a ^ r_b, r_a & r_b, ~r_a & r_b};
      w_mismatch   = (alu_result != w_golden);
      w_err_next   = r_err;
      if (w_mismatch && (r_err != '1))
         w_err_next = r_err + ERR_W'(1);
      w_idx_next   = r_idx + 2'd1;
      w_last_vec   = (r_idx == 2'd3);
      w_last_round = (r_round == 8'(ROUNDS - 1));
      w_lat_end    = (r_lat == 4'(LATENCY - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_lat        <= '0;
         r_round      <= '0;
         r_err        <= '0;
         r_a          <= 1'b0;
         r_b          <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
`ifdef ALU_BIST_FAIL_LOG_EN
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !abort) begin
                  r_state      <= S_APPLY;
                  r_idx        <= '0;
                  r_lat        <= '0;
                  r_round      <= '0;
                  r_err        <= '0;
                  r_pass       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_a          <= 1'b0;
                  r_b          <= 1'b0;
`ifdef ALU_BIST_FAIL_LOG_EN
                  r_fail_valid <= 1'b0;
                  r_fail_vec   <= '0;
`endif
               end
            end
            S_APPLY: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_lat   <= '0;
               end else if (w_lat_end) begin
                  r_state <= S_CHECK;
                  r_lat   <= '0;
               end else begin
                  r_lat <= r_lat + 4'd1;
               end
            end
            S_CHECK: begin
               if (abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_pass  <= 1'b0;
               end else begin
                  r_err <= w_err_next;
`ifdef ALU_BIST_FAIL_LOG_EN
                  if (w_mismatch && !r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_fail_vec   <= {r_a, r_b, 1'b0, alu_result};
                  end
`endif
                  // pass uses the post-update count so a final-vector miss still fails the run
                  if (w_last_vec && w_last_round) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_pass  <= (w_err_next == '0);
                  end else begin
                     r_state <= S_APPLY;
                     r_idx   <= w_idx_next;
                     r_a     <= w_idx_next[1];
                     r_b     <= w_idx_next[0];
                     if (w_last_vec)
                        r_round <= r_round + 8'd1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign alu_a      = r_a;
   assign alu_b      = r_b;
   assign alu_x      = 1'b0;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err;
`ifdef ALU_BIST_FAIL_LOG_EN
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;
`endif

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: two instances (L=1/R=4/E=8 and L=3/R=1/E=2) against a delayed slice model.
module tb_alu_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start0, abort0, start1, abort1;
   logic [1:0] mode0, mode1;   // 0 correct, 1 LT stuck at 0, 2 all inverted

   logic       a0, b0, x0, busy0, done0, pass0;
   logic [7:0] err0;
   logic       a1, b1, x1, busy1, done1, pass1;
   logic [1:0] err1;
   logic [4:0] res0;
   logic [4:0] pipe1 [3];
`ifdef ALU_BIST_FAIL_LOG_EN
   logic       fv0, fv1;
   logic [7:0] fvec0, fvec1;
`endif

   typedef struct {
      int unsigned busy_cyc;
      logic        pass;
      int unsigned err;
   } exp_t;
   exp_t exp_q[$];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   function automatic logic [4:0] slice(logic [1:0] mode, logic a, logic b);
      logic [4:0] g;
      case ({a, b})
         2'b00:   g = 5'b01000;
         2'b01:   g = 5'b10101;
         2'b10:   g = 5'b10100;
         default: g = 5'b11010;
      endcase
      if (mode == 2'd1) g[0] = 1'b0;
      else if (mode == 2'd2) g = ~g;
      return g;
   endfunction

   always_ff @(posedge clk) res0 <= slice(mode0, a0, b0);
   always_ff @(posedge clk) begin
      pipe1[0] <= slice(mode1, a1, b1);
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
   end

   alu_bist_ctrl u_dut0 (
      .clk(clk), .reset(rst_n), .start(start0), .abort(abort0),
      .alu_a(a0), .alu_b(b0), .alu_x(x0), .alu_result(res0),
      .busy(busy0), .done(done0), .pass(pass0),
`ifdef ALU_BIST_FAIL_LOG_EN
      .fail_valid(fv0), .fail_vec(fvec0),
`endif
      .err_count(err0)
   );

   alu_bist_ctrl #(.LATENCY(3), .ROUNDS(1), .ERR_W(2)) u_dut1 (
      .clk(clk), .reset(rst_n), .start(start1), .abort(abort1),
      .alu_a(a1), .alu_b(b1), .alu_x(x1), .alu_result(pipe1[2]),
      .busy(busy1), .done(done1), .pass(pass1),
`ifdef ALU_BIST_FAIL_LOG_EN
      .fail_valid(fv1), .fail_vec(fvec1),
`endif
      .err_count(err1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic run_bist(input int unsigned sel, input string tag,
                           input int unsigned exp_busy, input logic exp_pass, input int unsigned exp_err);
      exp_t        e;
      int unsigned cyc;
      logic        got;
      exp_q.push_back('{busy_cyc: exp_busy, pass: exp_pass, err: exp_err});
      @(negedge clk);
      if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ((sel == 1) ? done1 : done0) begin
            got = 1'b1;
            break;
         end
         if ((sel == 1) ? busy1 : busy0) cyc++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      if (!got) begin
         check({tag, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_busy_cycles"}, cyc, e.busy_cyc);
         check({tag, "_busy_at_done"}, 32'((sel == 1) ? busy1 : busy0), 32'd0);
         check({tag, "_pass"}, 32'((sel == 1) ? pass1 : pass0), 32'(e.pass));
         check({tag, "_err"}, (sel == 1) ? 32'(err1) : 32'(err0), e.err);
         @(negedge clk);
         check({tag, "_done_1cyc"}, 32'((sel == 1) ? done1 : done0), 32'd0);
      end
   endtask

   initial begin
      logic saw_done;
      rst_n = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      mode0 = 2'd0; mode1 = 2'd0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_pass", 32'(pass0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      check("rst_ab", 32'({a0, b0, x0}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // abort beats start in IDLE
      start0 = 1'b1; abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; abort0 = 1'b0;
      check("start_abort_busy", 32'(busy0), 32'd0);
      @(negedge clk);
      check("start_abort_busy2", 32'(busy0), 32'd0);

      run_bist(0, "clean0", 32, 1'b1, 0);
      repeat (3) @(negedge clk);
      check("hold_pass", 32'(pass0), 32'd1);
      check("hold_err", 32'(err0), 32'd0);
      check("alu_x", 32'(x0), 32'd0);

      mode0 = 2'd1;
      @(negedge clk);
      run_bist(0, "lt_stuck", 32, 1'b0, 4);
`ifdef ALU_BIST_FAIL_LOG_EN
      check("fail_valid", 32'(fv0), 32'd1);
      check("fail_vec", 32'(fvec0), 32'h54);
`endif

      // abort five cycles into a clean run
      mode0 = 2'd0;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy_before", 32'(busy0), 32'd1);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_pass", 32'(pass0), 32'd0);
      saw_done = done0;
      repeat (4) begin
         @(negedge clk);
         saw_done = saw_done | done0;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      run_bist(0, "after_abort", 32, 1'b1, 0);

      // reset asserted during the CHECK of vector 2 with LT stuck
      mode0 = 2'd1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (5) @(negedge clk);
      check("midrun_err", 32'(err0), 32'd1);
      check("midrun_ab", 32'({a0, b0}), 32'd2);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", 32'(busy0), 32'd0);
      check("async_rst_err", 32'(err0), 32'd0);
      check("async_rst_ab", 32'({a0, b0}), 32'd0);
`ifdef ALU_BIST_FAIL_LOG_EN
      check("async_rst_fv", 32'(fv0), 32'd0);
`endif
      @(negedge clk);
      check("rst_no_done", 32'(done0), 32'd0);
      rst_n = 1'b1;
      mode0 = 2'd0;
      @(negedge clk);
      run_bist(0, "after_reset", 32, 1'b1, 0);

      run_bist(1, "lat3_clean", 16, 1'b1, 0);
      mode1 = 2'd2;
      @(negedge clk);
      run_bist(1, "err_sat", 16, 1'b0, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
